result_store: RTL

Write-side counterpart of the classifier result path. It accepts the final dense-layer accumulator values one class at a time over a valid/ready handshake. Each value is rescaled by an arithmetic right shift and saturated to the memory word width. The result is written into consecutive words of the result memory starting at `memstartp`, after which `STOP` tells the top-level sequencer that the result region is complete and ready for the argmax reader.

---
 rtl/result_store.sv | 126 ++++++++++++
 1 files changed

// File: rtl/result_store.sv
// Result writer: rescales and saturates classifier accumulators into consecutive
// result-memory words, then raises STOP once the whole result region is written.
module result_store #(
    parameter int SIZE_1           = 12,
    parameter int SIZE_2           = 24,
    parameter int SIZE_address_pix = 13,
    parameter int NUM_CLASSES      = 11,
    parameter int SHIFT            = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [SIZE_address_pix-1:0] memstartp,
    input  logic [SIZE_2-1:0]           in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        we,
    output logic [SIZE_address_pix-1:0] write_addressp,
    output logic [SIZE_1-1:0]           dp,
    output logic                        STOP,
    output logic                        SAT
);

    localparam int CntW = $clog2(NUM_CLASSES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(NUM_CLASSES - 1);
    localparam logic signed [SIZE_2-1:0] SatMax = {{(SIZE_2-SIZE_1+1){1'b0}}, {(SIZE_1-1){1'b1}}};
    localparam logic signed [SIZE_2-1:0] SatMin = {{(SIZE_2-SIZE_1+1){1'b1}}, {(SIZE_1-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StAccept, StDone} state_e;

    state_e                      state_q, state_d;
    logic [CntW-1:0]             cnt_q, cnt_d;
    logic                        we_q, we_d;
    logic                        stop_q, stop_d;
    logic                        sat_q, sat_d;
    logic [SIZE_address_pix-1:0] addr_q, addr_d;
    logic [SIZE_1-1:0]           dp_q, dp_d;

    logic signed [SIZE_2-1:0]    shifted;
    logic [SIZE_1-1:0]           sat_val;
    logic                        clamp;

    // Rescale (floor) and clamp to the signed memory word range.
    always_comb begin
        shifted = $signed(in_data) >>> SHIFT;
        clamp   = 1'b0;
        sat_val = shifted[SIZE_1-1:0];
        if (shifted > SatMax) begin
            clamp   = 1'b1;
            sat_val = SatMax[SIZE_1-1:0];
        end else if (shifted < SatMin) begin
            clamp   = 1'b1;
            sat_val = SatMin[SIZE_1-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        dp_d    = dp_q;
        stop_d  = stop_q;
        sat_d   = sat_q;
        if (!enable) begin
            // Abort; SAT is kept so it stays readable after the run.
            state_d = StIdle;
            cnt_d   = '0;
            stop_d  = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StAccept;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                end
                StAccept: begin
                    if (in_valid) begin
                        we_d   = 1'b1;
                        addr_d = memstartp + SIZE_address_pix'(cnt_q);
                        dp_d   = sat_val;
                        sat_d  = sat_q | clamp;
                        cnt_d  = cnt_q + 1'b1;
                        if (cnt_q == CntLast) begin
                            state_d = StDone;
                        end
                    end
                end
                StDone: begin
                    stop_d = 1'b1;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            dp_q    <= '0;
            stop_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            dp_q    <= dp_d;
            stop_q  <= stop_d;
            sat_q   <= sat_d;
        end
    end

    assign in_ready       = (state_q == StAccept);
    assign we             = we_q;
    assign write_addressp = addr_q;
    assign dp             = dp_q;
    assign STOP           = stop_q;
    assign SAT            = sat_q;

endmodule
